// File: rtl/stuff_nrzi_enc_pkg.sv
// Shared definitions for the host transmit bit-stuffer / NRZI encoder.
//   - packet-type tag encodings carried alongside each serial bit
//   - FSM state encoding
//   - stuff threshold (run of ones that forces an inserted 0)
//   - saturating increment for the 6-bit stuffed-bit counter
package stuff_nrzi_enc_pkg;

  localparam logic [1:0] TYPE_NON  = 2'b00;
  localparam logic [1:0] TYPE_TOK  = 2'b01;
  localparam logic [1:0] TYPE_DATA = 2'b10;
  localparam logic [1:0] TYPE_HS   = 2'b11;

  localparam int unsigned STUFF_THRESH = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2
  } state_t;

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == '1) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/stuff_nrzi_enc_nrzi_enc.sv
// nrzi_enc: NRZI line-level register.
// Ports:
//   clk, rst_b  clock, async active-low reset (level resets to 1 = J)
//   nrz_bit     bit to encode (0 toggles the level, 1 holds it)
//   en          encode nrz_bit against the current level
//   restart     start from level 1 and encode nrz_bit in the same cycle;
//               the result is simply nrz_bit (1 holds J, 0 toggles to K)
//   level       current line level
module nrzi_enc (
  input  logic clk,
  input  logic rst_b,
  input  logic nrz_bit,
  input  logic en,
  input  logic restart,
  output logic level
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      level <= 1'b1;
    end else if (restart) begin
      level <= nrz_bit;
    end else if (en) begin
      level <= nrz_bit ? level : ~level;
    end
  end

endmodule

// File: rtl/stuff_nrzi_enc.sv
// stuff_nrzi_enc: serial bit-stuffer and NRZI encoder for the host TX path.
// Inserts a 0 after every six consecutive 1s, NRZI-encodes the stream and
// reports how many stuff bits went into the current/most recent packet.
// Build option: define BIT_STUFF_EN to enable stuffing; without it the block
// is a plain 1-cycle NRZI encoder (pause and stuffed tied to 0).
// Ports:
//   clk, rst_b  clock, async active-low reset
//   in_bit      raw packet bit from the serializer
//   in_type     packet type of in_bit (TYPE_NON = no bit)
//   pause       upstream must hold its inputs while high (stuff pending)
//   out_bit     NRZI line level, 1 = J, 0 = K
//   out_type    type tag aligned with out_bit
//   stuffed     stuff bits inserted in current/last packet, saturates at 63
module stuff_nrzi_enc
  import stuff_nrzi_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       in_bit,
  input  logic [1:0] in_type,
  output logic       pause,
  output logic       out_bit,
  output logic [1:0] out_type,
  output logic [5:0] stuffed
);

  state_t     state_q, state_d;
  logic [1:0] type_q, type_d;
  logic       enc_bit, enc_en, enc_restart;
`ifdef BIT_STUFF_EN
  logic [2:0] ones_q, ones_d;
  logic [5:0] stuffed_q, stuffed_d;
`endif

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    enc_bit     = in_bit;
    enc_en      = 1'b0;
    enc_restart = 1'b0;
`ifdef BIT_STUFF_EN
    ones_d      = ones_q;
    stuffed_d   = stuffed_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_type != TYPE_NON) begin
          enc_restart = 1'b1;
          type_d      = in_type;
          state_d     = SEND;
`ifdef BIT_STUFF_EN
          ones_d      = {2'b00, in_bit};
          stuffed_d   = '0;
`endif
        end
      end
      SEND: begin
        if (in_type == TYPE_NON) begin
          // Returning to idle parks the line at J via a restart with a 1.
          enc_bit     = 1'b1;
          enc_restart = 1'b1;
          type_d      = TYPE_NON;
          state_d     = IDLE;
`ifdef BIT_STUFF_EN
          ones_d      = '0;
`endif
        end else if (in_type != type_q) begin
          // A type change without an idle gap is a new packet start.
          enc_restart = 1'b1;
          type_d      = in_type;
`ifdef BIT_STUFF_EN
          ones_d      = {2'b00, in_bit};
          stuffed_d   = '0;
`endif
        end else begin
          enc_en = 1'b1;
`ifdef BIT_STUFF_EN
          if (in_bit) begin
            ones_d = ones_q + 3'd1;
            if (ones_q == 3'(STUFF_THRESH - 1)) begin
              state_d = STUFF;
            end
          end else begin
            ones_d = '0;
          end
`endif
        end
      end
`ifdef BIT_STUFF_EN
      STUFF: begin
        // Inputs are ignored here; upstream is holding under pause.
        enc_bit   = 1'b0;
        enc_en    = 1'b1;
        ones_d    = '0;
        stuffed_d = sat_inc6(stuffed_q);
        state_d   = SEND;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      type_q    <= TYPE_NON;
`ifdef BIT_STUFF_EN
      ones_q    <= '0;
      stuffed_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
`ifdef BIT_STUFF_EN
      ones_q    <= ones_d;
      stuffed_q <= stuffed_d;
`endif
    end
  end

  nrzi_enc u_nrzi (
    .clk     (clk),
    .rst_b   (rst_b),
    .nrz_bit (enc_bit),
    .en      (enc_en),
    .restart (enc_restart),
    .level   (out_bit)
  );

  assign out_type = type_q;
`ifdef BIT_STUFF_EN
  assign pause    = (state_q == STUFF);
  assign stuffed  = stuffed_q;
`else
  assign pause    = 1'b0;
  assign stuffed  = '0;
`endif

endmodule

// File: tb/tb_stuff_nrzi_enc.sv
// Directed self-checking bench for stuff_nrzi_enc. Expected values are
// hand-derived for both builds (BIT_STUFF_EN defined or not).
module tb_stuff_nrzi_enc;
  import stuff_nrzi_enc_pkg::*;

`ifdef BIT_STUFF_EN
  localparam bit STUFF_ON = 1'b1;
`else
  localparam bit STUFF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_b;
  logic       in_bit;
  logic [1:0] in_type;
  logic       pause;
  logic       out_bit;
  logic [1:0] out_type;
  logic [5:0] stuffed;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  stuff_nrzi_enc dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .in_bit   (in_bit),
    .in_type  (in_type),
    .pause    (pause),
    .out_bit  (out_bit),
    .out_type (out_type),
    .stuffed  (stuffed)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input int eb, input int et, input int ep, input int es);
    chk({tag, ".out_bit"},  16'(out_bit),  16'(eb));
    chk({tag, ".out_type"}, 16'(out_type), 16'(et));
    chk({tag, ".pause"},    16'(pause),    16'(ep));
    chk({tag, ".stuffed"},  16'(stuffed),  16'(es));
  endtask

  // Drive one input vector, clock it in, sample 1 ns after the edge.
  task automatic step(input logic b, input logic [1:0] t);
    in_bit  = b;
    in_type = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  sync_in, sync_exp;
    logic [10:0] run_in, run_exp;
    logic        p;
    int          acc, cyc, stalls, bad, run;

    // ---- reset ----
    rst_b   = 1'b0;
    in_bit  = 1'b0;
    in_type = TYPE_NON;
    #12;
    chk_out("reset", 1, 0, 0, 0);
    @(negedge clk);
    rst_b = 1'b1;
    step(1'b0, TYPE_NON);
    chk_out("idle", 1, 0, 0, 0);

    // ---- TOK SYNC: 0000_0001 -> KJKJKJKK ----
    sync_in  = 8'b1000_0000;
    sync_exp = 8'b0010_1010;
    for (int i = 0; i < 8; i++) begin
      step(sync_in[i], TYPE_TOK);
      chk_out($sformatf("sync%0d", i), int'(sync_exp[i]), 1, 0, 0);
    end
    step(1'b0, TYPE_NON);
    chk_out("sync_end", 1, 0, 0, 0);

    // ---- type change mid-stream restarts from J ----
    step(1'b0, TYPE_TOK);  chk_out("tc0", 0, 1, 0, 0);
    step(1'b1, TYPE_DATA); chk_out("tc1", 1, 2, 0, 0);
    step(1'b0, TYPE_DATA); chk_out("tc2", 0, 2, 0, 0);
    step(1'b0, TYPE_HS);   chk_out("tc3", 0, 3, 0, 0);
    step(1'b0, TYPE_NON);  chk_out("tc4", 1, 0, 0, 0);

    // ---- five 1s, 0, five 1s: a 0 clears the run, no stuffing ----
    run_in  = 11'b111_1101_1111;
    run_exp = 11'b000_0001_1111;
    for (int i = 0; i < 11; i++) begin
      step(run_in[i], TYPE_DATA);
      chk_out($sformatf("run%0d", i), int'(run_exp[i]), 2, 0, 0);
    end
    step(1'b0, TYPE_NON);

    // ---- DATA: 0 then eight 1s ----
    step(1'b0, TYPE_DATA);
    chk_out("d8_0", 0, 2, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, TYPE_DATA);
      chk_out($sformatf("d8_%0d", k), 0, 2, (STUFF_ON && k == 6) ? 1 : 0, 0);
    end
    if (STUFF_ON) begin
      step(1'b1, TYPE_DATA);  // held input, stuff bit emitted
      chk_out("d8_stuff", 1, 2, 0, 1);
      step(1'b1, TYPE_DATA); chk_out("d8_7", 1, 2, 0, 1);
      step(1'b1, TYPE_DATA); chk_out("d8_8", 1, 2, 0, 1);
      step(1'b0, TYPE_NON);  chk_out("d8_end", 1, 0, 0, 1);
    end else begin
      step(1'b1, TYPE_DATA); chk_out("d8_7", 0, 2, 0, 0);
      step(1'b1, TYPE_DATA); chk_out("d8_8", 0, 2, 0, 0);
      step(1'b0, TYPE_NON);  chk_out("d8_end", 1, 0, 0, 0);
    end

    // ---- six 1s as the final bits, then NON ----
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, TYPE_DATA);
      chk_out($sformatf("f6_%0d", k), 1, 2, (STUFF_ON && k == 6) ? 1 : 0, 0);
    end
    if (STUFF_ON) begin
      step(1'b0, TYPE_NON); chk_out("f6_stuff", 0, 2, 0, 1);
      step(1'b0, TYPE_NON); chk_out("f6_end", 1, 0, 0, 1);
      step(1'b0, TYPE_NON); chk_out("f6_hold", 1, 0, 0, 1);
    end else begin
      step(1'b0, TYPE_NON); chk_out("f6_end", 1, 0, 0, 0);
    end
    step(1'b1, TYPE_TOK); chk_out("f6_next", 1, 1, 0, 0);
    step(1'b0, TYPE_NON);

    // ---- 450 consecutive 1s: cadence and saturation ----
    acc = 0; cyc = 0; stalls = 0; bad = 0; run = 0;
    in_bit  = 1'b1;
    in_type = TYPE_DATA;
    while (acc < 450 && cyc < 2000) begin
      p = pause;
      @(posedge clk); #1;
      cyc++;
      if (!p) begin
        acc++; run++;
      end else begin
        if (run != 6) bad++;
        run = 0; stalls++;
      end
    end
    chk("long.accepted", 16'(acc), 16'd450);
    chk("long.pause_after_last", 16'(pause), 16'(STUFF_ON));
    if (pause) begin
      @(posedge clk); #1;
      if (run != 6) bad++;
      stalls++;
    end
    chk("long.stalls", 16'(stalls), STUFF_ON ? 16'd75 : 16'd0);
    chk("long.bad_cadence", 16'(bad), 16'd0);
    chk("long.stuffed", 16'(stuffed), STUFF_ON ? 16'd63 : 16'd0);
    chk("long.out_bit", 16'(out_bit), STUFF_ON ? 16'd0 : 16'd1);
    step(1'b0, TYPE_NON);
    chk_out("long_end", 1, 0, 0, STUFF_ON ? 63 : 0);

    // ---- async reset while in STUFF (second stuff of a packet) ----
    for (int k = 0; k < 13; k++) step(1'b1, TYPE_DATA);
    chk_out("rs_pre", STUFF_ON ? 0 : 1, 2, STUFF_ON ? 1 : 0, STUFF_ON ? 1 : 0);
    #2 rst_b = 1'b0;
    #1;
    chk_out("rs_async", 1, 0, 0, 0);
    @(negedge clk);
    rst_b = 1'b1;
    step(1'b0, TYPE_NON);
    chk_out("rs_idle", 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stuff_nrzi_enc.md
# stuff_nrzi_enc

Serial bit-stuffer and NRZI encoder for the host transmit path. It sits between the CRC/serializer stage and the DP/DM write stage. It consumes the raw packet bitstream with its packet-type tag and inserts a 0 after every six consecutive 1s. It NRZI-encodes the result and hands the encoded bit, the type tag and a running stuffed-bit count to the DP/DM writer, which uses that count to extend its packet length.

## Interface
Parameters:
- none. Packet-type encodings come from the shared package.

Ports:
- `clk`  in  1  system clock.
- `rst_b`  in  1  reset. Asynchronous, active-low.
- `in_bit`  in  1  raw (unstuffed, un-encoded) packet bit from the serializer.
- `in_type`  in  2  packet type of `in_bit`. `TYPE_NON` (2'b00) means no bit. `TYPE_TOK`=01, `TYPE_DATA`=10, `TYPE_HS`=11.
- `pause`  out  1  while 1, upstream must hold `in_bit`/`in_type`; the bit is not consumed.
- `out_bit`  out  1  NRZI-encoded line level. 1 = J, 0 = K.
- `out_type`  out  2  type tag aligned with `out_bit`. Drives the writer's ready/type input.
- `stuffed`  out  6  number of stuff bits inserted in the current or most recent packet. Saturates at 63.

## Operation
- States: `IDLE`, `SEND`, `STUFF`.
- Input bit accepted at a posedge when `in_type != TYPE_NON` and `pause == 0`.
- NRZI rule:
  - The level register starts at 1 (J).
  - An accepted 0 toggles the level.
  - An accepted 1 holds the level.
  - `out_bit` is the new level.
- Ones counter (3 bits, 0..6):
  - An accepted 1 increments it.
  - An accepted 0 or a stuff bit clears it.
- IDLE:
  - On an accepted bit: clear `stuffed` and the ones counter, set level to 1, encode the bit, load `out_type <= in_type`, go to SEND.
  - Otherwise outputs hold the idle values (`out_bit`=1, `out_type`=NON). `stuffed` holds its last value.
- SEND:
  - Encode each accepted bit.
  - If the accepted bit is the sixth consecutive 1, go to STUFF.
  - `in_type` NON sampled → `out_type <= NON`, `out_bit <= 1`, level <= 1, go to IDLE.
  - `in_type` changes to a different nonzero type → treat as a new packet start: same actions as IDLE acceptance, stay in SEND.
- STUFF:
  - `pause` = 1. Inputs are ignored.
  - At the next posedge: toggle level (stuffed 0), `out_type` keeps the packet type, ones <= 0, `stuffed <= stuffed+1` (saturating at 63), go to SEND.
  - The stuff bit is emitted even if `in_type` is already NON. The sixth 1 as the last packet bit still gets its stuff bit before the end.
- `pause` is a Moore output: 1 exactly when state == STUFF.

## Timing
- Latency: 1 cycle. A bit accepted at posedge k appears on `out_bit`/`out_type` from posedge k until posedge k+1.
- A stuff bit occupies one output cycle, and `pause` is high during the cycle before it is emitted. Upstream sees exactly one stall per inserted bit.
- `stuffed` updates in the same cycle the stuff bit appears on `out_bit`.
- Reset values:
  - State IDLE, level 1, ones 0.
  - `out_bit`=1, `out_type`=00, `stuffed`=0, `pause`=0.
- Reset asserted mid-packet or mid-STUFF: all outputs take their reset values immediately (asynchronous). The partial packet is dropped.

## Configuration
- `BIT_STUFF_EN`
  - Defined: stuffing behaves as above.
  - Undefined: the STUFF state and ones counter are removed. `pause` is tied 0, `stuffed` is tied 0, and the block is a pure 1-cycle NRZI encoder.

## Structure
- Shared package: `TYPE_NON/TOK/DATA/HS` encodings, the state enum, and the stuff threshold constant (6).
- One sub-module, `nrzi_enc`, holds the level register. Its inputs are bit, enable and restart; its output is the level. The top owns the FSM, ones counter and `stuffed` counter.

## Test plan
- Reset: hold `rst_b`=0 → `out_bit`=1, `out_type`=00, `stuffed`=0, `pause`=0.
- TOK SYNC: in_bit 0,0,0,0,0,0,0,1 with type 01 → out_bit 0,1,0,1,0,1,0,0 (KJKJKJKK), type 01, one cycle late, `pause` never high.
- DATA with eight 1s after a 0:
  - `pause` is high for exactly one cycle after the sixth 1.
  - A level toggle is inserted.
  - `stuffed`=1.
  - The last two 1s hold the level.
  - Total 10 output cycles.
- Six 1s as final bits, then type 00 → stuff bit emitted with `out_type`=10, then `out_type`=00, `out_bit`=1. `stuffed` stays 1 until the next packet starts.
- 450 consecutive 1s → `stuffed` saturates at 63. Stall cadence stays one `pause` per six 1s throughout.
- `rst_b` pulsed low while in STUFF → `pause` falls immediately and outputs reset. With `BIT_STUFF_EN` undefined, eight 1s give no `pause` and `stuffed`=0.
